imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 112 +++++++++++
 tb/tb_imem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-core instruction fetch arbiter in front of one shared synchronous instruction memory.
// Define IMEM_ARB_FIXED_PRIO_EN to make core 0 always win ties; by default ties are round-robin.
module imem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [XLEN-1:0] addr0,
  input  logic            flush0,
  input  logic            req1,
  input  logic [XLEN-1:0] addr1,
  input  logic            flush1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic [XLEN-1:0] rdata0,
  output logic            rvalid1,
  output logic [XLEN-1:0] rdata1,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instr
);

  // Handshake: a request is held until gnt is seen in the same cycle; the word
  // comes back exactly one cycle later as a single-cycle rvalid pulse.
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic            pend0_q, pend0_d;
  logic            pend1_q, pend1_d;
  logic [XLEN-1:0] rdata0_q, rdata0_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d;

`ifdef IMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end
  end
`else
  // last_gnt_q = 1 means core 1 was granted most recently, so core 0 wins the next tie.
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    last_gnt_d = last_gnt_q;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
      if (gnt0) begin
        last_gnt_d = 1'b0;
      end else if (gnt1) begin
        last_gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  always_comb begin
    imem_en = gnt0 | gnt1;
    imem_pc = '0;
    if (gnt0) begin
      imem_pc = addr0 & ALIGN_MASK;
    end else if (gnt1) begin
      imem_pc = addr1 & ALIGN_MASK;
    end
  end

  // A flush in the return cycle masks the response; the memory word is simply dropped.
  always_comb begin
    pend0_d  = gnt0 & ~flush0;
    pend1_d  = gnt1 & ~flush1;
    rvalid0  = pend0_q & ~flush0 & ~rst;
    rvalid1  = pend1_q & ~flush1 & ~rst;
    rdata0_d = rvalid0 ? imem_instr : rdata0_q;
    rdata1_d = rvalid1 ? imem_instr : rdata1_q;
    rdata0   = rdata0_d;
    rdata1   = rdata1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      pend0_q  <= pend0_d;
      pend1_q  <= pend1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, hand sequences for
// flush/reset corners, and random traffic against a transaction-level reference model.
module tb_imem_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            req0, req1, flush0, flush1;
  logic [XLEN-1:0] addr0, addr1;
  logic            gnt0, gnt1, rvalid0, rvalid1, imem_en;
  logic [XLEN-1:0] rdata0, rdata1, imem_pc, imem_instr;

  int n_vec = 0;
  int n_err = 0;

  imem_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .flush0(flush0),
    .req1(req1), .addr1(addr1), .flush1(flush1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0),
    .rvalid1(rvalid1), .rdata1(rdata1),
    .imem_en(imem_en), .imem_pc(imem_pc), .imem_instr(imem_instr)
  );

  // ---------------- clock / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] mem_f(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  initial imem_instr = '0;
  always @(posedge clk) if (imem_en) imem_instr <= mem_f(imem_pc);

`ifdef IMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- reference model ----------------
  int              last_win = 1;   // core that won most recently
  int              fl_core  = -1;  // core owning the read currently in memory
  logic [XLEN-1:0] fl_addr  = '0;
  bit              fl_kill  = 1'b0;
  logic [XLEN-1:0] hold0 = '0, hold1 = '0;
  int              e_win;
  logic [XLEN-1:0] e_pc, e_rd0, e_rd1;
  bit              e_rv0, e_rv1;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    if (rst) e_win = -1;
    else if (req0 && req1) e_win = FIXED ? 0 : (last_win == 0 ? 1 : 0);
    else if (req0) e_win = 0;
    else if (req1) e_win = 1;
    else e_win = -1;
    e_pc  = (e_win == 0) ? {addr0[XLEN-1:2], 2'b00} :
            (e_win == 1) ? {addr1[XLEN-1:2], 2'b00} : '0;
    e_rv0 = !rst && fl_core == 0 && !fl_kill && !flush0;
    e_rv1 = !rst && fl_core == 1 && !fl_kill && !flush1;
    e_rd0 = e_rv0 ? mem_f(fl_addr) : hold0;
    e_rd1 = e_rv1 ? mem_f(fl_addr) : hold1;
    chk("gnt0",    {31'b0, gnt0},    {31'b0, e_win == 0});
    chk("gnt1",    {31'b0, gnt1},    {31'b0, e_win == 1});
    chk("imem_en", {31'b0, imem_en}, {31'b0, e_win >= 0});
    chk("imem_pc", imem_pc, e_pc);
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, e_rv0});
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, e_rv1});
    chk("rdata0",  rdata0, e_rd0);
    chk("rdata1",  rdata1, e_rd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit q0, input bit q1,
                       input logic [XLEN-1:0] a0, input logic [XLEN-1:0] a1,
                       input bit f0, input bit f1);
    @(negedge clk);
    rst = r; req0 = q0; req1 = q1; addr0 = a0; addr1 = a1; flush0 = f0; flush1 = f1;
    #1;
    model_check();
  endtask

  task automatic tick();
    bit was_rst, f0, f1;
    was_rst = rst; f0 = flush0; f1 = flush1;
    @(posedge clk);
    if (was_rst) begin
      last_win = 1; fl_core = -1; fl_kill = 1'b0; hold0 = '0; hold1 = '0;
    end else begin
      if (e_rv0) hold0 = e_rd0;
      if (e_rv1) hold1 = e_rd1;
      fl_core = e_win;
      if (e_win >= 0) begin
        last_win = e_win;
        fl_addr  = e_pc;
        fl_kill  = (e_win == 0) ? f0 : f1;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit r, q0, q1, f0, f1;
    logic [XLEN-1:0] a0, a1;
    bit e_g0, e_g1, e_rv0, e_rv1;
    logic [XLEN-1:0] e_pc;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit r, bit q0, bit q1, logic [XLEN-1:0] a0, logic [XLEN-1:0] a1,
                              bit g0, bit g1, logic [XLEN-1:0] pc, bit rv0, bit rv1);
    vec_t v;
    v.r = r; v.q0 = q0; v.q1 = q1; v.f0 = 1'b0; v.f1 = 1'b0; v.a0 = a0; v.a1 = a1;
    v.e_g0 = g0; v.e_g1 = g1; v.e_pc = pc; v.e_rv0 = rv0; v.e_rv1 = rv1;
    return v;
  endfunction

  logic [XLEN-1:0] saved;

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; flush0 = 0; flush1 = 0; addr0 = '0; addr1 = '0;
    repeat (2) @(posedge clk);

    tbl[0]  = mk(1, 1, 1, 32'h100, 32'h400, 0, 0, 32'h0,   0, 0);
    tbl[1]  = mk(0, 1, 0, 32'h100, 32'h0,   1, 0, 32'h100, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 0);
    tbl[3]  = mk(1, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 0);
`ifdef IMEM_ARB_FIXED_PRIO_EN
    tbl[4]  = mk(0, 1, 1, 32'h0, 32'h400, 1, 0, 32'h0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 32'h0, 32'h400, 1, 0, 32'h0, 1, 0);
    tbl[6]  = mk(0, 1, 1, 32'h0, 32'h400, 1, 0, 32'h0, 1, 0);
    tbl[7]  = mk(0, 1, 1, 32'h0, 32'h400, 1, 0, 32'h0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 32'h0, 32'h0,   0, 0, 32'h0, 1, 0);
`else
    tbl[4]  = mk(0, 1, 1, 32'h0, 32'h400, 1, 0, 32'h0,   0, 0);
    tbl[5]  = mk(0, 1, 1, 32'h0, 32'h400, 0, 1, 32'h400, 1, 0);
    tbl[6]  = mk(0, 1, 1, 32'h0, 32'h400, 1, 0, 32'h0,   0, 1);
    tbl[7]  = mk(0, 1, 1, 32'h0, 32'h400, 0, 1, 32'h400, 1, 0);
    tbl[8]  = mk(0, 0, 0, 32'h0, 32'h0,   0, 0, 32'h0,   0, 1);
`endif
    tbl[9]  = mk(0, 1, 0, 32'h103, 32'h0, 1, 0, 32'h100, 0, 0);
    tbl[10] = mk(0, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0,   1, 0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].q0, tbl[i].q1, tbl[i].a0, tbl[i].a1, tbl[i].f0, tbl[i].f1);
      chk($sformatf("tbl%0d_gnt0", i), {31'b0, gnt0}, {31'b0, tbl[i].e_g0});
      chk($sformatf("tbl%0d_gnt1", i), {31'b0, gnt1}, {31'b0, tbl[i].e_g1});
      chk($sformatf("tbl%0d_pc", i), imem_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_rv0", i), {31'b0, rvalid0}, {31'b0, tbl[i].e_rv0});
      chk($sformatf("tbl%0d_rv1", i), {31'b0, rvalid1}, {31'b0, tbl[i].e_rv1});
      if (i == 2)  chk("tbl2_rdata0", rdata0, mem_f(32'h100));
      if (i == 10) chk("tbl10_rdata0", rdata0, mem_f(32'h100));
      tick();
    end

    // Flush core 1 in its return cycle while core 0 fetches.
    drive(0, 0, 1, 32'h0, 32'h20, 0, 0);
    chk("fl_gnt1", {31'b0, gnt1}, 32'd1);
    saved = rdata1;
    tick();
    drive(0, 1, 0, 32'h40, 32'h0, 0, 1);
    chk("fl_rv1", {31'b0, rvalid1}, 32'd0);
    chk("fl_rd1_hold", rdata1, saved);
    chk("fl_gnt0", {31'b0, gnt0}, 32'd1);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("fl_rv0", {31'b0, rvalid0}, 32'd1);
    chk("fl_rd0", rdata0, mem_f(32'h40));
    chk("fl_rd1_hold2", rdata1, saved);
    tick();

    // Flush core 0 in its grant cycle.
    drive(0, 1, 0, 32'h80, 32'h0, 1, 0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("gf_rv0", {31'b0, rvalid0}, 32'd0);
    tick();

    // Reset lands in the return cycle of a core 0 fetch.
    drive(0, 1, 0, 32'h200, 32'h0, 0, 0);
    tick();
    drive(1, 1, 1, 32'h200, 32'h300, 0, 0);
    chk("rst_rv0", {31'b0, rvalid0}, 32'd0);
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_en", {31'b0, imem_en}, 32'd0);
    tick();
    drive(0, 1, 1, 32'h0, 32'h400, 0, 0);
    chk("post_rst_rv0", {31'b0, rvalid0}, 32'd0);
    chk("post_rst_rd0", rdata0, 32'd0);
    chk("post_rst_tie", {31'b0, gnt0}, 32'd1);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
